// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx among N_REQ byte requesters, round-robin, timing each frame plus gap in ck_en ticks.
// Define UART_TX_SCHED_PRIO_EN to give requester 0 priority over the rotating group 1..N_REQ-1.
module uart_tx_sched #(
  parameter int N_REQ         = 4,
  parameter int ID_W          = 2,
  parameter int TICKS_PER_BIT = 16,
  parameter int FRAME_BITS    = 10,
  parameter int GAP_BITS      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ck_en,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);

  localparam logic [15:0] FRAME_TICKS = 16'(TICKS_PER_BIT * (FRAME_BITS + GAP_BITS));

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_reg;
  logic [15:0]     cnt_reg;
  logic [ID_W-1:0] rr_ptr_reg;

  logic [N_REQ-1:0] rot_mask;
  logic [N_REQ-1:0] above_mask;
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] pool_req;
  logic [N_REQ-1:0] pick_onehot;
  logic [N_REQ-1:0] grant_onehot;
  logic [N_REQ-1:0] id_sel [ID_W];
  logic [N_REQ-1:0] byte_sel [8];
  logic [ID_W-1:0]  pick_id;
  logic [7:0]       pick_byte;

`ifdef UART_TX_SCHED_PRIO_EN
  logic last_zero_reg;
  assign rot_mask = {{(N_REQ-1){1'b1}}, 1'b0};
`else
  assign rot_mask = '1;
`endif

  // Requesters above rr_ptr come first; if none, wrap to the lowest set one.
  assign hi_req      = req & rot_mask & above_mask;
  assign pool_req    = (|hi_req) ? hi_req : (req & rot_mask);
  assign pick_onehot = pool_req & (~pool_req + N_REQ'(1));

`ifdef UART_TX_SCHED_PRIO_EN
  // Requester 0 yields exactly one turn after its own grant so the others are not starved.
  assign grant_onehot = (req[0] && !(last_zero_reg && (|pool_req))) ? N_REQ'(1) : pick_onehot;
`else
  assign grant_onehot = pick_onehot;
`endif

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign above_mask[gi] = (ID_W'(gi) > rr_ptr_reg);
    for (genvar gb = 0; gb < 8; gb++) begin : g_byte
      assign byte_sel[gb][gi] = grant_onehot[gi] & req_data[8*gi+gb];
    end
    for (genvar gb = 0; gb < ID_W; gb++) begin : g_id
      if (((gi >> gb) & 1) == 1) begin : g_one
        assign id_sel[gb][gi] = grant_onehot[gi];
      end else begin : g_zero
        assign id_sel[gb][gi] = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte_or
    assign pick_byte[gi] = |byte_sel[gi];
  end

  for (genvar gi = 0; gi < ID_W; gi++) begin : g_id_or
    assign pick_id[gi] = |id_sel[gi];
  end

  // Reset lands in HOLD so a frame uart_tx may still be shifting drains first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= HOLD;
      cnt_reg    <= '0;
      rr_ptr_reg <= ID_W'(N_REQ-1);
      ack        <= '0;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      busy       <= 1'b1;
`ifdef UART_TX_SCHED_PRIO_EN
      last_zero_reg <= 1'b0;
`endif
    end else begin
      ack   <= '0;
      tx_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            tx_en     <= 1'b1;
            ack       <= grant_onehot;
            tx_data   <= pick_byte;
            grant_id  <= pick_id;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= HOLD;
`ifdef UART_TX_SCHED_PRIO_EN
            last_zero_reg <= grant_onehot[0];
            if (!grant_onehot[0]) rr_ptr_reg <= pick_id;
`else
            rr_ptr_reg <= pick_id;
`endif
          end
        end
        HOLD: begin
          if (ck_en) begin
            if (cnt_reg == FRAME_TICKS - 16'd1) begin
              cnt_reg   <= '0;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a frame-window reference model predicts each grant; a monitor checks the DUT.
module tb_uart_tx_sched;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int FT    = 22;
  localparam int M_ONESHOT = 0;
  localparam int M_HOLD    = 1;
  localparam int M_RAND    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ck_en = 1'b0;
  logic [N_REQ-1:0]   req = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   ack;
  logic               tx_en;
  logic [7:0]         tx_data;
  logic [ID_W-1:0]    grant_id;
  logic               busy;

  uart_tx_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .TICKS_PER_BIT(2), .FRAME_BITS(10), .GAP_BITS(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ck_en(ck_en), .req(req), .req_data(req_data),
    .ack(ack), .tx_en(tx_en), .tx_data(tx_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_grants = 0;
  int cyc = 0;

  // reference model state
  bit         m_idle;
  int         m_left;
  int         m_rr;
  bit         m_last0;
  logic       exp_busy;
  logic [7:0] exp_data;
  int         exp_gid;

  // stimulus state
  int ph = 0;
  bit ck_run = 1'b0;
  int mode = M_ONESHOT;
  int ticks_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic bit bit_of(input logic [N_REQ-1:0] v, input int i);
    logic [N_REQ-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*N_REQ-1:0] d, input int i);
    logic [8*N_REQ-1:0] sh;
    sh = d >> (8*i);
    return sh[7:0];
  endfunction

  // Next requester to serve, from the rotation rule.
  function automatic int model_pick(input logic [N_REQ-1:0] r, input int rr, input bit last0);
    int cand;
    int k;
    cand = -1;
`ifdef UART_TX_SCHED_PRIO_EN
    for (int s = 1; s < N_REQ; s++) begin
      k = 1 + ((rr - 1 + s) % (N_REQ - 1));
      if (cand < 0 && bit_of(r, k)) cand = k;
    end
    if (bit_of(r, 0) && !(last0 && cand >= 0)) cand = 0;
`else
    for (int s = 1; s <= N_REQ; s++) begin
      k = (rr + s) % N_REQ;
      if (cand < 0 && bit_of(r, k)) cand = k;
    end
`endif
    return cand;
  endfunction

  // Model: a frame window of FT ticks after reset or a grant; a grant on the first edge after it closes.
  always @(posedge clk) begin
    int   id;
    exp_t e;
    cyc = cyc + 1;
    if (!reset_n) begin
      m_idle = 1'b0; m_left = FT; m_rr = N_REQ - 1; m_last0 = 1'b0;
      exp_busy = 1'b1; exp_data = 8'h00; exp_gid = 0;
    end else if (!m_idle) begin
      if (ck_en) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_idle = 1'b1;
          exp_busy = 1'b0;
        end
      end
    end else if (req != '0) begin
      id = model_pick(req, m_rr, m_last0);
      e.cyc = cyc; e.id = id; e.data = byte_of(req_data, id);
      exp_q.push_back(e);
`ifdef UART_TX_SCHED_PRIO_EN
      if (id != 0) m_rr = id;
      m_last0 = (id == 0);
`else
      m_rr = id;
`endif
      m_idle = 1'b0; m_left = FT;
      exp_busy = 1'b1; exp_data = e.data; exp_gid = id;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic [N_REQ-1:0] oh;
    if (reset_n) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("tx_data_hold", 32'(tx_data), 32'(exp_data));
      chk("grant_id_hold", 32'(grant_id), 32'(exp_gid));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_grants++;
        oh = N_REQ'(1) << e.id;
        $display("grant %0d: cyc=%0d id=%0d data=%02h ack=%b tx_en=%b", n_grants, cyc, grant_id, tx_data, ack, tx_en);
        chk("tx_en", 32'(tx_en), 32'd1);
        chk("ack", 32'(ack), 32'(oh));
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("tx_data", 32'(tx_data), 32'(e.data));
      end else begin
        chk("tx_en_quiet", 32'(tx_en), 32'd0);
        chk("ack_quiet", 32'(ack), 32'd0);
      end
    end
  end

  function automatic int consumed();
    return ticks_total - (ck_en ? 1 : 0);
  endfunction

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      if (bit_of(ack, i)) begin
        if (mode == M_ONESHOT || (mode == M_RAND && $urandom_range(0, 1) == 0)) req[i] = 1'b0;
        else if (mode == M_RAND) req_data[8*i +: 8] = 8'($urandom);
      end else if (mode == M_RAND) begin
        if (!req[i] && $urandom_range(0, 99) < 4) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 999) < 3) begin
          req[i] = 1'b0;
        end
      end
    end
    ph = (ph == 6) ? 0 : ph + 1;
    ck_en = ck_run && (ph == 6);
    if (ck_en) ticks_total++;
  endtask

  task automatic wait_tx(input string name, input int mark, output int ticks);
    ticks = -1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (tx_en) begin
        ticks = consumed() - mark;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL %s: no tx_en within 600 cycles, got none, expected a grant", name);
  endtask

  task automatic wait_idle(input string name, input int mark, output int ticks);
    ticks = -1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!busy) begin
        ticks = consumed() - mark;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL %s: busy stuck high for 600 cycles, expected release", name);
  endtask

  initial begin
    int t;
    int mark;
    int g0;
    int order3[5];
`ifdef UART_TX_SCHED_PRIO_EN
    order3 = '{0, 1, 0, 2, 0};
`else
    order3 = '{0, 1, 2, 3, 0};
`endif
    mode = M_ONESHOT;
    repeat (3) step();
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // T1: drain window after reset
    req = 4'b0001; req_data[7:0] = 8'h3C;
    reset_n = 1'b1; ck_run = 1'b1; mark = consumed();
    wait_tx("t1_grant", mark, t);
    chk("t1_drain_ticks", 32'(t), 32'd22);
    chk("t1_ack", 32'(ack), 32'b0001);

    // T2: single send from idle
    wait_idle("t1_idle", mark, t);
    req[2] = 1'b1; req_data[23:16] = 8'hA5;
    step();
    chk("t2_tx_en", 32'(tx_en), 32'd1);
    chk("t2_tx_data", 32'(tx_data), 32'hA5);
    chk("t2_ack", 32'(ack), 32'b0100);
    chk("t2_grant_id", 32'(grant_id), 32'd2);
    mark = consumed();
    wait_idle("t2_idle", mark, t);
    chk("t2_busy_ticks", 32'(t), 32'd22);

    // T3: all four held, after a grant to 3 so rotation starts at 0
    req[3] = 1'b1; req_data[31:24] = 8'h43;
    step();
    chk("t3_pre_grant", 32'(grant_id), 32'd3);
    mark = consumed();
    mode = M_HOLD;
    req = 4'b1111; req_data = 32'h43322110;
    for (int n = 0; n < 5; n++) begin
      wait_tx("t3_grant", mark, t);
      chk("t3_order", 32'(grant_id), 32'(order3[n]));
      chk("t3_spacing_ticks", 32'(t), 32'd22);
      mark = consumed();
    end
    mode = M_ONESHOT; req = '0;
    wait_idle("t3_idle", mark, t);

    // T4: withdrawal during HOLD, then a ck_en stall
    req[3] = 1'b1; req_data[31:24] = 8'h5A;
    step();
    chk("t4_tx_en", 32'(tx_en), 32'd1);
    mark = consumed();
    req[1] = 1'b1; req_data[15:8] = 8'hEE;
    repeat (3) step();
    req[1] = 1'b0;
    g0 = n_grants;
    ck_run = 1'b0;
    repeat (150) step();
    chk("t4_stall_busy", 32'(busy), 32'd1);
    chk("t4_stall_grants", 32'(n_grants), 32'(g0));
    ck_run = 1'b1;
    wait_idle("t4_idle", mark, t);
    chk("t4_ticks", 32'(t), 32'd22);
    chk("t4_withdraw_grants", 32'(n_grants), 32'(g0));

    // T5: reset at cnt=10
    req[0] = 1'b1; req_data[7:0] = 8'hC3;
    step();
    chk("t5_tx_en", 32'(tx_en), 32'd1);
    mark = consumed();
    for (int c = 0; c < 600 && (consumed() - mark) < 10; c++) step();
    chk("t5_cnt_reached", 32'(consumed() - mark), 32'd10);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_tx_en", 32'(tx_en), 32'd0);
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'h00);
    chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd1);
    req[1] = 1'b1; req_data[15:8] = 8'h77;
    ck_run = 1'b0;
    repeat (3) step();
    reset_n = 1'b1; ck_run = 1'b1; mark = consumed();
    wait_tx("t5_grant", mark, t);
    chk("t5_drain_ticks", 32'(t), 32'd22);
    chk("t5_grant_id", 32'(grant_id), 32'd1);
    mark = consumed();
    wait_idle("t5_idle", mark, t);

    // Randomised traffic
    mode = M_RAND;
    repeat (6000) step();
    mode = M_ONESHOT; req = '0;
    wait_idle("final_idle", consumed(), t);
    repeat (5) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
